// File: rtl/msrv32_trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// MSRV32_TRAP_WFI_EN widens the state encoding to add the WFI wait state.
package msrv32_trap_pkg;

`ifdef MSRV32_TRAP_WFI_EN
    typedef enum logic [2:0] {
        StReset      = 3'd0,
        StOperating  = 3'd1,
        StTrapTaken  = 3'd2,
        StTrapReturn = 3'd3,
        StWaitIrq    = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        StReset      = 2'd0,
        StOperating  = 2'd1,
        StTrapTaken  = 2'd2,
        StTrapReturn = 2'd3
    } state_e;
`endif

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [3:0] CAUSE_MSI              = 4'd3;
    localparam logic [3:0] CAUSE_MTI              = 4'd7;
    localparam logic [3:0] CAUSE_MEI              = 4'd11;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_NEXT = 2'b10;
    localparam logic [1:0] PC_TRAP = 2'b11;

    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
    localparam logic [6:0] F7_ECALL   = 7'b0000000;
    localparam logic [6:0] F7_EBREAK  = 7'b0000000;
    localparam logic [6:0] F7_MRET    = 7'b0011000;
    localparam logic [6:0] F7_WFI     = 7'b0001000;
    localparam logic [4:0] RS2_ECALL  = 5'd0;
    localparam logic [4:0] RS2_EBREAK = 5'd1;
    localparam logic [4:0] RS2_MRET   = 5'd2;
    localparam logic [4:0] RS2_WFI    = 5'd5;

    // Exceptions whose mtval is the faulting address rather than zero.
    function automatic logic is_addr_cause(input logic [3:0] cause);
        return (cause == CAUSE_INSTR_MISALIGNED) || (cause == CAUSE_LOAD_MISALIGNED) ||
               (cause == CAUSE_STORE_MISALIGNED);
    endfunction

endpackage

// File: rtl/msrv32_trap_priority.sv
// Combinational trap priority encoder: exceptions first, then MIE-gated interrupts.
module msrv32_trap_priority
    import msrv32_trap_pkg::*;
(
    input  logic       misaligned_instr_in,
    input  logic       illegal_in,
    input  logic       ebreak_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       ecall_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       msie_in,
    input  logic       mtie_in,
    input  logic       meip_in,
    input  logic       msip_in,
    input  logic       mtip_in,
    output logic       trap_valid_out,
    output logic       i_or_e_out,
    output logic [3:0] cause_out
);
    logic w_exc;
    logic w_mei;
    logic w_msi;
    logic w_mti;
    logic w_irq;

    assign w_exc = misaligned_instr_in | illegal_in | ebreak_in | misaligned_load_in |
                   misaligned_store_in | ecall_in;
    assign w_mei = meie_in & meip_in;
    assign w_msi = msie_in & msip_in;
    assign w_mti = mtie_in & mtip_in;
    assign w_irq = mie_in & (w_mei | w_msi | w_mti);

    assign trap_valid_out = w_exc | w_irq;
    assign i_or_e_out     = ~w_exc & w_irq;

    always_comb begin
        cause_out = CAUSE_INSTR_MISALIGNED;
        if (misaligned_instr_in)      cause_out = CAUSE_INSTR_MISALIGNED;
        else if (illegal_in)          cause_out = CAUSE_ILLEGAL;
        else if (ebreak_in)           cause_out = CAUSE_BREAKPOINT;
        else if (misaligned_load_in)  cause_out = CAUSE_LOAD_MISALIGNED;
        else if (misaligned_store_in) cause_out = CAUSE_STORE_MISALIGNED;
        else if (ecall_in)            cause_out = CAUSE_ECALL_M;
        else if (w_mei)               cause_out = CAUSE_MEI;
        else if (w_msi)               cause_out = CAUSE_MSI;
        else if (w_mti)               cause_out = CAUSE_MTI;
    end

endmodule

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap control FSM driving CSR trap controls and the fetch PC source.
// Define MSRV32_TRAP_WFI_EN to add the WFI wait state and wfi_stall_out.
module msrv32_trap_controller
    import msrv32_trap_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       i_or_e_out,
    output logic [3:0] cause_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       instret_inc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       misaligned_exception_out,
    output logic [1:0] pc_src_out,
`ifdef MSRV32_TRAP_WFI_EN
    output logic       wfi_stall_out,
`endif
    output logic       flush_out
);
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_e     r_state;
    logic [3:0] r_boot_cnt;
    logic [3:0] r_cause;
    logic       r_i_or_e;

    logic       w_system;
    logic       w_ecall;
    logic       w_ebreak;
    logic       w_mret;
    logic       w_wfi;
    logic       w_illegal;
    logic       w_trap;
    logic       w_i_or_e;
    logic [3:0] w_cause;

    assign w_system = (opcode_6_to_2_in == OPC_SYSTEM) && (funct3_in == 3'b000) &&
                      (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall  = w_system && (funct7_in == F7_ECALL) && (rs2_addr_in == RS2_ECALL);
    assign w_ebreak = w_system && (funct7_in == F7_EBREAK) && (rs2_addr_in == RS2_EBREAK);
    assign w_mret   = w_system && (funct7_in == F7_MRET) && (rs2_addr_in == RS2_MRET);
    assign w_wfi    = w_system && (funct7_in == F7_WFI) && (rs2_addr_in == RS2_WFI);

`ifdef MSRV32_TRAP_WFI_EN
    logic w_irq_any;
    assign w_irq_any = (meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in);
    assign w_illegal = illegal_instr_in;
`else
    // Without WFI support the encoding is just another illegal instruction.
    assign w_illegal = illegal_instr_in | w_wfi;
`endif

    msrv32_trap_priority u_priority (
        .misaligned_instr_in (misaligned_instr_in),
        .illegal_in          (w_illegal),
        .ebreak_in           (w_ebreak),
        .misaligned_load_in  (misaligned_load_in),
        .misaligned_store_in (misaligned_store_in),
        .ecall_in            (w_ecall),
        .mie_in              (mie_in),
        .meie_in             (meie_in),
        .msie_in             (msie_in),
        .mtie_in             (mtie_in),
        .meip_in             (meip_in),
        .msip_in             (msip_in),
        .mtip_in             (mtip_in),
        .trap_valid_out      (w_trap),
        .i_or_e_out          (w_i_or_e),
        .cause_out           (w_cause)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= StReset;
            r_boot_cnt <= 4'd0;
            r_cause    <= 4'd0;
            r_i_or_e   <= 1'b0;
        end else begin
            case (r_state)
                StReset: begin
                    r_boot_cnt <= r_boot_cnt + 4'd1;
                    if (r_boot_cnt == BOOT_LAST) r_state <= StOperating;
                end
                StOperating: begin
                    if (w_trap) begin
                        r_cause  <= w_cause;
                        r_i_or_e <= w_i_or_e;
                        r_state  <= StTrapTaken;
                    end else if (w_mret) begin
                        r_state <= StTrapReturn;
`ifdef MSRV32_TRAP_WFI_EN
                    end else if (w_wfi) begin
                        r_state <= StWaitIrq;
`endif
                    end
                end
                StTrapTaken:  r_state <= StOperating;
                StTrapReturn: r_state <= StOperating;
`ifdef MSRV32_TRAP_WFI_EN
                StWaitIrq: if (w_irq_any) r_state <= StOperating;
`endif
                default:      r_state <= StReset;
            endcase
        end
    end

    assign cause_out  = r_cause;
    assign i_or_e_out = r_i_or_e;

    always_comb begin
        set_cause_out            = 1'b0;
        set_epc_out              = 1'b0;
        instret_inc_out          = 1'b0;
        mie_clear_out            = 1'b0;
        mie_set_out              = 1'b0;
        misaligned_exception_out = 1'b0;
        pc_src_out               = PC_BOOT;
        flush_out                = 1'b1;
`ifdef MSRV32_TRAP_WFI_EN
        wfi_stall_out            = 1'b0;
`endif
        // Reset masks everything so a trap caught in its last cycle never pulses set_*.
        if (!rst_in) begin
            case (r_state)
                StOperating: begin
                    pc_src_out      = PC_NEXT;
                    flush_out       = w_trap | w_mret;
                    instret_inc_out = ~(w_trap | w_mret);
                end
                StTrapTaken: begin
                    set_cause_out            = 1'b1;
                    set_epc_out              = 1'b1;
                    mie_clear_out            = 1'b1;
                    pc_src_out               = PC_TRAP;
                    misaligned_exception_out = ~r_i_or_e & is_addr_cause(r_cause);
                end
                StTrapReturn: begin
                    mie_set_out = 1'b1;
                    pc_src_out  = PC_EPC;
                end
`ifdef MSRV32_TRAP_WFI_EN
                StWaitIrq: begin
                    wfi_stall_out = 1'b1;
                    pc_src_out    = PC_NEXT;
                    flush_out     = 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
